// File: rtl/mem_arb_pkg.sv
// Shared types for the pixel-memory port arbiter: FSM state, grant owner and
// the access-timeout counter width.
package mem_arb_pkg;

    localparam int TCNT_W = 8;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        RD_ACC  = 3'd1,
        WR_ACC  = 3'd2,
        RD_DONE = 3'd3,
        WR_DONE = 3'd4
    } arb_state_t;

    typedef enum logic {
        READ  = 1'b0,
        WRITE = 1'b1
    } grant_t;

endpackage

// File: rtl/req_latch.sv
// One request channel: a pending flag plus the payload (address, optionally
// data) captured with the request, and a same-cycle overrun indication.
module req_latch #(
    parameter int PW = 32
) (
    input  logic          clk,
    input  logic          n_rst,
    input  logic          set,
    input  logic          clear,
    input  logic [PW-1:0] payload_in,
    output logic          pend,
    output logic [PW-1:0] payload,
    output logic          overrun
);

    // A request landing on the completion cycle replaces the finished one.
    assign overrun = set & pend & ~clear;

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            pend    <= 1'b0;
            payload <= '0;
        end else if (set && (!pend || clear)) begin
            pend    <= 1'b1;
            payload <= payload_in;
        end else if (clear) begin
            pend <= 1'b0;
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one pixel-memory port between the control
// unit's read and write channels, with an access timeout.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              n_rst,
    input  logic              i_re,
    input  logic [ADDR_W-1:0] i_raddr,
    input  logic              i_we,
    input  logic [ADDR_W-1:0] i_waddr,
    input  logic [DATA_W-1:0] i_wdata,
    input  logic              i_clear_err,
    input  logic              i_mem_ready,
    input  logic [DATA_W-1:0] i_mem_rdata,
    output logic [ADDR_W-1:0] o_mem_addr,
    output logic              o_mem_ren,
    output logic              o_mem_wen,
    output logic [DATA_W-1:0] o_mem_wdata,
    output logic [DATA_W-1:0] o_rdata,
    output logic              o_read_complete,
    output logic              o_write_complete,
    output logic              o_busy,
    output logic              o_err,
    output logic [2:0]        o_dbg_state
);

    arb_state_t               state;
    grant_t                   last_grant;
    logic [TCNT_W-1:0]        tcnt;
    logic                     rd_pend, wr_pend, rd_ovr, wr_ovr;
    logic                     rd_clr, wr_clr, in_acc, tmo_hit;
    logic                     state_nx_idle, busy_nx;
    logic [ADDR_W-1:0]        rd_addr;
    logic [ADDR_W+DATA_W-1:0] wr_payload;

    req_latch #(.PW(ADDR_W)) u_rd_latch (
        .clk        (clk),
        .n_rst      (n_rst),
        .set        (i_re),
        .clear      (rd_clr),
        .payload_in (i_raddr),
        .pend       (rd_pend),
        .payload    (rd_addr),
        .overrun    (rd_ovr)
    );

    req_latch #(.PW(ADDR_W + DATA_W)) u_wr_latch (
        .clk        (clk),
        .n_rst      (n_rst),
        .set        (i_we),
        .clear      (wr_clr),
        .payload_in ({i_waddr, i_wdata}),
        .pend       (wr_pend),
        .payload    (wr_payload),
        .overrun    (wr_ovr)
    );

    // Memory handshake: a strobe and its address/data stay stable until a
    // cycle with i_mem_ready high, which completes the access; i_mem_ready
    // outside an access is ignored, and a stall of TIMEOUT cycles aborts it.
    assign in_acc  = (state == RD_ACC) || (state == WR_ACC);
    assign tmo_hit = in_acc && !i_mem_ready && (tcnt == TCNT_W'(TIMEOUT - 1));
    assign rd_clr  = (state == RD_ACC) && (i_mem_ready || tmo_hit);
    assign wr_clr  = (state == WR_ACC) && (i_mem_ready || tmo_hit);

    // o_busy is registered from next-cycle pending/state so it lines up with them.
    assign state_nx_idle = ((state == IDLE) && !rd_pend && !wr_pend) ||
                           (state == RD_DONE) || (state == WR_DONE);
    assign busy_nx = i_re || (rd_pend && !rd_clr) ||
                     i_we || (wr_pend && !wr_clr) || !state_nx_idle;

    assign o_dbg_state = state;

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state            <= IDLE;
            last_grant       <= WRITE;
            tcnt             <= '0;
            o_mem_addr       <= '0;
            o_mem_ren        <= 1'b0;
            o_mem_wen        <= 1'b0;
            o_mem_wdata      <= '0;
            o_rdata          <= '0;
            o_read_complete  <= 1'b0;
            o_write_complete <= 1'b0;
            o_busy           <= 1'b0;
            o_err            <= 1'b0;
        end else begin
            o_read_complete  <= 1'b0;
            o_write_complete <= 1'b0;
            o_busy           <= busy_nx;
            if (rd_ovr || wr_ovr || tmo_hit) begin
                o_err <= 1'b1;
            end else if (i_clear_err) begin
                o_err <= 1'b0;
            end

            case (state)
                IDLE: begin
                    if (rd_pend && (!wr_pend || last_grant == WRITE)) begin
                        state      <= RD_ACC;
                        last_grant <= READ;
                        tcnt       <= '0;
                        o_mem_ren  <= 1'b1;
                        o_mem_addr <= rd_addr;
                    end else if (wr_pend) begin
                        state       <= WR_ACC;
                        last_grant  <= WRITE;
                        tcnt        <= '0;
                        o_mem_wen   <= 1'b1;
                        o_mem_addr  <= wr_payload[ADDR_W+DATA_W-1:DATA_W];
                        o_mem_wdata <= wr_payload[DATA_W-1:0];
                    end
                end
                RD_ACC: begin
                    if (i_mem_ready || tmo_hit) begin
                        state           <= RD_DONE;
                        o_mem_ren       <= 1'b0;
                        o_mem_addr      <= '0;
                        o_read_complete <= 1'b1;
                        o_rdata         <= i_mem_ready ? i_mem_rdata : '0;
                    end else begin
                        tcnt <= tcnt + 1'b1;
                    end
                end
                WR_ACC: begin
                    if (i_mem_ready || tmo_hit) begin
                        state            <= WR_DONE;
                        o_mem_wen        <= 1'b0;
                        o_mem_addr       <= '0;
                        o_mem_wdata      <= '0;
                        o_write_complete <= 1'b1;
                    end else begin
                        tcnt <= tcnt + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
